// File: rtl/cyq_seq_detector_param.sv
// cyq_seq_detector_param
// Parametrised Moore serial sequence detector. It shifts a single-bit stream
// into a history register and compares it against a run-time reloadable
// pattern. The registered flag Y marks each completed match. Matches are
// counted in a saturating counter.
//
// Flow control: there is no valid/ready pair on this block. En is a
// one-directional sample qualifier. X is consumed on a rising edge only when
// En=1, and the block can never stall its source. Pat_Load takes precedence
// over En, so an edge that loads a pattern consumes no data bit.
module cyq_seq_detector_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b011,
    parameter int               CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             X,
    input  logic             Overlap,
    input  logic             Pat_Load,
    input  logic [PAT_W-1:0] Pat_In,
    input  logic             Clr_Cnt,
    output logic             Y,
    output logic [CNT_W-1:0] Match_Cnt,
    output logic             Cnt_Sat
);

    // fill counts valid history bits and saturates at PAT_W.
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ZERO = '0;

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  pat;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_inc;
    logic              sample;
    logic              match;

    // The bit is consumed only when no pattern load claims the edge.
    assign sample = En & ~Pat_Load;

    // Compute the history and fill level the current edge would produce,
    // and decide whether that edge completes a match.
    always_comb begin
        hist_n   = {hist[PAT_W-2:0], X};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        match    = sample && (fill_inc == FILL_FULL) && (hist_n == pat);
    end

    // Active pattern register. It reloads to PATTERN on reset and to Pat_In
    // on a load strobe.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pat <= PATTERN;
        end else if (Pat_Load) begin
            pat <= Pat_In;
        end
    end

    // Bit history. It shifts on sampled edges and is left intact by a
    // pattern load, because fill alone decides which history bits count.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hist <= '0;
        end else if (sample) begin
            hist <= hist_n;
        end
    end

    // Fill level. A load restarts it. A non-overlapping match also restarts
    // it, so the next match needs PAT_W fresh bits. An overlapping match keeps
    // it full, so a match can complete on the very next sampled bit.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fill <= FILL_ZERO;
        end else if (Pat_Load) begin
            fill <= FILL_ZERO;
        end else if (En) begin
            if (match) begin
                fill <= Overlap ? FILL_FULL : FILL_ZERO;
            end else begin
                fill <= fill_inc;
            end
        end
    end

    // Moore match flag. It is updated only on consumed bits, so it holds its
    // value through En=0 stalls.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Y <= 1'b0;
        end else if (Pat_Load) begin
            Y <= 1'b0;
        end else if (En) begin
            Y <= match;
        end
    end

    // Saturating match counter. A clear wins over a match on the same edge.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Match_Cnt <= '0;
        end else if (Clr_Cnt) begin
            Match_Cnt <= '0;
        end else if (match && !Cnt_Sat) begin
            Match_Cnt <= Match_Cnt + 1'b1;
        end
    end

    // Saturation flag, decoded straight from the counter register.
    assign Cnt_Sat = &Match_Cnt;

endmodule

// File: tb/tb_cyq_seq_detector_param.sv
// Testbench for cyq_seq_detector_param. It uses three instances:
//   u0: default PAT_W=3, PATTERN=011, CNT_W=8
//   u1: PAT_W=3, CNT_W=2 (exercises counter saturation)
//   u2: PAT_W=8, PATTERN=A5 (exercises the wide pattern)
// A stream-based reference model is checked on every falling edge.
// Directed sequences add hand-computed literal checks.
module tb_cyq_seq_detector_param;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    // ---------------- DUT stimulus / outputs ----------------
    logic [2:0] en_v  = '0;
    logic [2:0] x_v   = '0;
    logic [2:0] ov_v  = '0;
    logic [2:0] pl_v  = '0;
    logic [2:0] clr_v = '0;
    logic [2:0] pin0  = '0;
    logic [2:0] pin1  = '0;
    logic [7:0] pin2  = '0;

    logic [2:0] y_v;
    logic [2:0] sat_v;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;

    cyq_seq_detector_param u0 (
        .Clk(Clk), .Rst(Rst), .En(en_v[0]), .X(x_v[0]), .Overlap(ov_v[0]),
        .Pat_Load(pl_v[0]), .Pat_In(pin0), .Clr_Cnt(clr_v[0]),
        .Y(y_v[0]), .Match_Cnt(cnt0), .Cnt_Sat(sat_v[0])
    );

    cyq_seq_detector_param #(.PAT_W(3), .PATTERN(3'b011), .CNT_W(2)) u1 (
        .Clk(Clk), .Rst(Rst), .En(en_v[1]), .X(x_v[1]), .Overlap(ov_v[1]),
        .Pat_Load(pl_v[1]), .Pat_In(pin1), .Clr_Cnt(clr_v[1]),
        .Y(y_v[1]), .Match_Cnt(cnt1), .Cnt_Sat(sat_v[1])
    );

    cyq_seq_detector_param #(.PAT_W(8), .PATTERN(8'hA5), .CNT_W(8)) u2 (
        .Clk(Clk), .Rst(Rst), .En(en_v[2]), .X(x_v[2]), .Overlap(ov_v[2]),
        .Pat_Load(pl_v[2]), .Pat_In(pin2), .Clr_Cnt(clr_v[2]),
        .Y(y_v[2]), .Match_Cnt(cnt2), .Cnt_Sat(sat_v[2])
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance keeps the whole list of consumed bits plus the index where
    // matching may start again (after reset, a pattern load or a
    // non-overlapping match). A match means at least PAT_W bits lie since that
    // index and the last PAT_W of them spell the pattern, MSB first.
    bit          stream [3][1024];
    int          len    [3];
    int          start  [3];
    logic [15:0] m_pat  [3];
    bit          m_y    [3];
    int          m_cnt  [3];

    function automatic int pat_w(int i);
        return (i == 2) ? 8 : 3;
    endfunction

    function automatic int cnt_max(int i);
        return (i == 1) ? 3 : 255;
    endfunction

    function automatic logic [15:0] reset_pat(int i);
        return (i == 2) ? 16'h00A5 : 16'h0003;
    endfunction

    function automatic logic [15:0] pin_of(int i);
        case (i)
            0:       return {13'b0, pin0};
            1:       return {13'b0, pin1};
            default: return {8'b0, pin2};
        endcase
    endfunction

    function automatic bit ends_with_pat(int i);
        int w;
        w = pat_w(i);
        if (len[i] - start[i] < w) return 1'b0;
        for (int k = 0; k < w; k++) begin
            if (stream[i][len[i] - w + k] != m_pat[i][w - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset(int i);
        len[i]   = 0;
        start[i] = 0;
        m_pat[i] = reset_pat(i);
        m_y[i]   = 1'b0;
        m_cnt[i] = 0;
    endtask

    task automatic model_step(int i);
        bit m;
        m = 1'b0;
        if (pl_v[i]) begin
            m_pat[i] = pin_of(i);
            start[i] = len[i];
            m_y[i]   = 1'b0;
        end else if (en_v[i]) begin
            stream[i][len[i]] = x_v[i];
            len[i]++;
            m      = ends_with_pat(i);
            m_y[i] = m;
            if (m && !ov_v[i]) start[i] = len[i];
        end
        if (clr_v[i]) m_cnt[i] = 0;
        else if (m && m_cnt[i] < cnt_max(i)) m_cnt[i]++;
    endtask

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 3; i++) model_reset(i);
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        check("cyc_y0",   y_v[0],    m_y[0]);
        check("cyc_cnt0", int'(cnt0), m_cnt[0]);
        check("cyc_sat0", sat_v[0],  int'(m_cnt[0] == cnt_max(0)));
        check("cyc_y1",   y_v[1],    m_y[1]);
        check("cyc_cnt1", int'(cnt1), m_cnt[1]);
        check("cyc_sat1", sat_v[1],  int'(m_cnt[1] == cnt_max(1)));
        check("cyc_y2",   y_v[2],    m_y[2]);
        check("cyc_cnt2", int'(cnt2), m_cnt[2]);
        check("cyc_sat2", sat_v[2],  int'(m_cnt[2] == cnt_max(2)));
    end

    // ---------------- driver tasks ----------------
    // Called at negedge+1. Applies one edge's inputs, then returns at the
    // next negedge+1 with the strobes dropped, so outputs are settled.
    task automatic drive(int i, bit e, bit xx, bit ld, logic [15:0] pin, bit c);
        en_v[i]  = e;
        x_v[i]   = xx;
        pl_v[i]  = ld;
        clr_v[i] = c;
        case (i)
            0:       pin0 = pin[2:0];
            1:       pin1 = pin[2:0];
            default: pin2 = pin[7:0];
        endcase
        @(negedge Clk);
        #1;
        en_v[i]  = 1'b0;
        pl_v[i]  = 1'b0;
        clr_v[i] = 1'b0;
    endtask

    task automatic send_bit(int i, bit xx);
        drive(i, 1'b1, xx, 1'b0, 16'h0, 1'b0);
    endtask

    function automatic int dut_y(int i);
        return int'(y_v[i]);
    endfunction

    function automatic int dut_cnt(int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic lit(int i, string tag, int ey, int ec);
        check({tag, "_y"},   dut_y(i),   ey);
        check({tag, "_cnt"}, dut_cnt(i), ec);
    endtask

    // ---------------- directed stimulus ----------------
    bit t1_x [6] = '{0, 1, 1, 0, 1, 1};
    int t1_y [6] = '{0, 0, 1, 0, 0, 1};
    int t1_c [6] = '{0, 0, 1, 1, 1, 2};
    bit t2_x [5] = '{1, 0, 1, 0, 1};
    int t2o_y[5] = '{0, 0, 1, 0, 1};
    int t2o_c[5] = '{0, 0, 1, 1, 2};
    int t2n_y[5] = '{0, 0, 1, 0, 0};
    int t2n_c[5] = '{0, 0, 1, 1, 1};

    initial begin
        logic [11:0] wide_bits;
        logic [7:0]  a5;
        logic [6:0]  part;

        // Reset
        #1 Rst = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        lit(0, "rst0", 0, 0);
        check("rst_sat0", sat_v[0], 0);
        Rst = 1'b1;

        // T1: default 011, non-overlapping
        ov_v[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_bit(0, t1_x[k]);
            lit(0, $sformatf("t1_b%0d", k + 1), t1_y[k], t1_c[k]);
        end

        // T2a: load 101 (with clear), overlapping
        ov_v[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b1, 16'h5, 1'b1);
        lit(0, "t2_load", 0, 0);
        for (int k = 0; k < 5; k++) begin
            send_bit(0, t2_x[k]);
            lit(0, $sformatf("t2ov_b%0d", k + 1), t2o_y[k], t2o_c[k]);
        end

        // T2b: reload 101 (with clear), non-overlapping
        ov_v[0] = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            send_bit(0, t2_x[k]);
            lit(0, $sformatf("t2no_b%0d", k + 1), t2n_y[k], t2n_c[k]);
        end

        // T3: pattern 011, stall in the middle, then stall while Y is high
        drive(0, 1'b0, 1'b0, 1'b1, 16'h3, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            lit(0, $sformatf("t3_stall%0d", k), 0, 0);
        end
        send_bit(0, 1'b1);
        lit(0, "t3_match", 1, 1);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            lit(0, $sformatf("t3_hold%0d", k), 1, 1);
        end

        // T4: load 110, partial 0,1, reset pulse, then the 011 pattern must be back
        drive(0, 1'b0, 1'b0, 1'b1, 16'h6, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        Rst = 1'b0;
        @(negedge Clk);
        #1;
        lit(0, "t4_rst", 0, 0);
        Rst = 1'b1;
        send_bit(0, 1'b1);
        lit(0, "t4_after", 0, 0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        lit(0, "t4_b3", 0, 0);
        send_bit(0, 1'b1);
        lit(0, "t4_pat_restored", 1, 1);

        // T5: 2-bit counter saturation, then clear on a match edge
        ov_v[1] = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            send_bit(1, 1'b0);
            send_bit(1, 1'b1);
            send_bit(1, 1'b1);
            lit(1, $sformatf("t5_rep%0d", r), 1, (r < 3) ? r : 3);
            check($sformatf("t5_sat%0d", r), sat_v[1], (r >= 3) ? 1 : 0);
        end
        send_bit(1, 1'b0);
        send_bit(1, 1'b1);
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        lit(1, "t5_clr_on_match", 1, 0);
        check("t5_clr_sat", sat_v[1], 0);

        // T6: 8-bit pattern A5, overlapping; A5 then 5 matches only at bit 8
        ov_v[2] = 1'b1;
        wide_bits = 12'hA55;
        for (int k = 11; k >= 0; k--) begin
            send_bit(2, wide_bits[k]);
            lit(2, $sformatf("t6_b%0d", 12 - k), (k == 4) ? 1 : 0, (k > 4) ? 0 : 1);
        end
        // Load on the edge that would complete A5: no match, count held
        part = 7'b1010010;
        for (int k = 6; k >= 0; k--) send_bit(2, part[k]);
        lit(2, "t6_pre_load", 0, 1);
        drive(2, 1'b1, 1'b1, 1'b1, 16'h00A5, 1'b0);
        lit(2, "t6_load_edge", 0, 1);
        // First match after the load needs 8 fresh bits
        a5 = 8'hA5;
        for (int k = 7; k >= 0; k--) begin
            send_bit(2, a5[k]);
            lit(2, $sformatf("t6_fresh%0d", 8 - k), (k == 0) ? 1 : 0, (k == 0) ? 2 : 1);
        end

        repeat (2) @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cyq_seq_detector_param.md
# cyq_seq_detector_param

Parametrised Moore serial sequence detector: the next generation of the team's fixed 3-bit "011" detector. Pattern width, reset-time pattern and match-counter width are parameters. The pattern is reloadable at run time, overlapping/non-overlapping detection is selectable, and matches are counted with saturation. It sits on a single-bit serial input stream in the lab's digital-logic designs and drives a registered match flag plus a count for display.

## Interface
Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..16.
- PATTERN, 3'b011, pattern loaded at reset; MSB is the first bit received.
- CNT_W, 8, match counter width; minimum 2.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- En  in  1  sample enable; X is consumed only on edges with En=1.
- X  in  1  serial data input.
- Overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- Pat_Load  in  1  synchronous pattern load strobe.
- Pat_In  in  PAT_W  new pattern, captured when Pat_Load=1.
- Clr_Cnt  in  1  synchronous match-counter clear.
- Y  out  1  registered Moore match flag.
- Match_Cnt  out  CNT_W  number of matches, saturating.
- Cnt_Sat  out  1  1 while Match_Cnt is all-ones.

## Operation
State registers:
- hist[PAT_W-1:0]: bit history.
- fill: number of valid history bits, 0..PAT_W, saturating at PAT_W; width clog2(PAT_W+1).
- pat[PAT_W-1:0]: active pattern.
- Y, Match_Cnt.

Reset (Rst=0, asynchronous):
- hist=0, fill=0, pat=PATTERN, Y=0, Match_Cnt=0, Cnt_Sat=0.
- Rst low mid-sequence discards any partial match.

Per rising edge, in priority order:
1. Pat_Load=1:
   - pat<=Pat_In, fill<=0, Y<=0, hist unchanged.
   - X is ignored even if En=1.
   - Match_Cnt is unaffected, except that Clr_Cnt still applies.
2. Else if En=1:
   - hist_n={hist[PAT_W-2:0],X}; fill_n=min(fill+1,PAT_W).
   - match = (fill_n==PAT_W) && (hist_n==pat).
   - hist<=hist_n; Y<=match.
   - On match with Overlap=0: fill<=0, so the next match needs PAT_W fresh bits.
   - On match with Overlap=1: fill<=PAT_W.
   - No match: fill<=fill_n.
3. Else (En=0): hist, fill and Y hold. Y is a pure function of state, so it stays asserted while stalled.

Counter:
- On an edge where match=1: Match_Cnt<=Match_Cnt+1, holding at 2^CNT_W-1.
- Clr_Cnt=1 has priority: Match_Cnt<=0, even if match occurs on the same edge.
- Cnt_Sat = &Match_Cnt, decoded from the register with no extra latency.

Mode change: Overlap is sampled on each edge, so a change affects only matches completing on or after that edge.

## Timing
- Y rises on the same rising edge that samples the last pattern bit; it is visible in the following cycle. This is the same single-state Moore latency as the fixed "011" detector.
- Y lasts exactly one cycle per match while En stays 1, unless the next sampled bit completes another match (overlap mode, periodic patterns).
- Match_Cnt updates on the same edge as Y.
- Pat_Load: the first match against the new pattern needs PAT_W enabled edges after the load edge.
- No combinational path from any input to any output.

## Test plan
- Default pattern 011, Overlap=0, En=1, X=0,1,1,0,1,1 → Y high one cycle after the 3rd and after the 6th sampled bit; Match_Cnt=2.
- Pat_Load with Pat_In=3'b101, then X=1,0,1,0,1:
  - Overlap=1 → Y high after bits 3 and 5, Match_Cnt=2.
  - Overlap=0 → Y high after bit 3 only, Match_Cnt=1.
- Pattern 011; X=0,1, then En=0 for 3 cycles, then X=1 with En=1 → match on the 3rd enabled bit. Then En=0 → Y stays high while stalled.
- Rst pulsed low after X=0,1, then X=1 → no match; Y=0, Match_Cnt=0; pat returns to 011 even after a prior Pat_Load.
- CNT_W=2, repeat 011 five times:
  - Match_Cnt reaches 3 with Cnt_Sat=1 and holds at 3.
  - Clr_Cnt on a match edge → Match_Cnt=0, Cnt_Sat=0.
- PAT_W=8, PATTERN=8'hA5, Overlap=1, stream of bits A5 then 5 → Y after bit 8 only.
  - Assert Pat_Load on the same edge as a would-be completing bit → Y=0, Match_Cnt unchanged.
